// File: rtl/gg_rowslice_writer.sv
// ---------------------------------------------------------------------------
// gg_rowslice_writer
//
// Encoder-side row-slice writer. On slice_start it latches the P-slice header
// fields, serialises them (Exp-Golomb ue/se plus fixed-width fields), then
// appends the upstream data elements (mb_skip_run ue codes and raw payload
// chunks). It finishes with rbsp trailing bits. The result is an MSB-first,
// byte-aligned word stream.
//
// Ports
//   clk, reset          clock; synchronous active-low reset (0 = reset)
//   slice_start         start pulse; header fields are latched when busy=0
//   first_mb .. dblk_beta
//                       slice header fields (see field order in HDR below)
//   busy                slice in progress, from accept to slice_end
//   el_valid/el_ready   data-element handshake
//   el_kind             0 = skip run ue(el_data[15:0]), 1 = raw chunk
//   el_data/el_len      raw chunk bits el_data[31 -: el_len], length 1..32
//   el_last             final element of the slice
//   out_data/out_valid/out_ready
//                       output word handshake; first bit at out_data[WIDTH-1]
//   out_nbytes          valid bytes in out_data (WIDTH/8 except last word)
//   out_last            last word of the slice
//   slice_end           1-cycle pulse after the out_last word is accepted
// ---------------------------------------------------------------------------
module gg_rowslice_writer #(
  parameter int WIDTH    = 32,
  parameter int FN_BITS  = 4,
  parameter int POC_BITS = 4,
  localparam int NBW     = $clog2(WIDTH / 8) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                slice_start,
  input  logic [15:0]         first_mb,
  input  logic [3:0]          slice_type,
  input  logic [7:0]          pps_id,
  input  logic [FN_BITS-1:0]  frame_num,
  input  logic [POC_BITS-1:0] poc_lsb,
  input  logic signed [6:0]   qp_delta,
  input  logic [1:0]          dblk_idc,
  input  logic signed [3:0]   dblk_alpha,
  input  logic signed [3:0]   dblk_beta,
  output logic                busy,
  input  logic                el_valid,
  output logic                el_ready,
  input  logic                el_kind,
  input  logic [31:0]         el_data,
  input  logic [5:0]          el_len,
  input  logic                el_last,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NBW-1:0]      out_nbytes,
  output logic                out_last,
  output logic                slice_end
);

  // Accumulator: valid bits sit MSB-aligned in acc_q[ACC-1 -: fill_q].
  localparam int ACC = WIDTH + 32;
  localparam int FW  = $clog2(ACC + 1);
  localparam logic [FW-1:0] WIDTH_F = FW'(WIDTH);
  localparam logic [FW-1:0] ACC_F   = FW'(ACC);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  // Header field indices, written one per cycle in this order.
  localparam logic [3:0] F_FIRST_MB = 4'd0;
  localparam logic [3:0] F_TYPE     = 4'd1;
  localparam logic [3:0] F_PPS      = 4'd2;
  localparam logic [3:0] F_FN       = 4'd3;
  localparam logic [3:0] F_POC      = 4'd4;
  localparam logic [3:0] F_FLAG0    = 4'd5;
  localparam logic [3:0] F_FLAG1    = 4'd6;
  localparam logic [3:0] F_FLAG2    = 4'd7;
  localparam logic [3:0] F_QP       = 4'd8;
  localparam logic [3:0] F_IDC      = 4'd9;
  localparam logic [3:0] F_ALPHA    = 4'd10;
  localparam logic [3:0] F_BETA     = 4'd11;

  // ue(v) length for x = v+1: 2*floor(log2(x)) + 1.
  function automatic logic [5:0] ue_len(input logic [16:0] x);
    logic [5:0] l;
    l = 6'd1;
    for (int i = 1; i < 17; i++) begin
      if (x[i]) l = 6'(2 * i + 1);
    end
    return l;
  endfunction

  // se(k) -> ue code number: k>0 -> 2k-1, k<=0 -> -2k.
  function automatic logic [16:0] se_map(input int k);
    return (k > 0) ? 17'(2 * k - 1) : 17'(-2 * k);
  endfunction

  // State
  logic [2:0]          state_q, state_d;
  logic [3:0]          hdr_idx_q, hdr_idx_d;
  logic [ACC-1:0]      acc_q, acc_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [NBW-1:0]      out_nbytes_q, out_nbytes_d;
  logic                out_last_q, out_last_d;
  logic                slice_end_q, slice_end_d;

  // Latched header fields
  logic [15:0]         fm_q;
  logic [3:0]          st_q;
  logic [7:0]          pps_q;
  logic [FN_BITS-1:0]  fn_q;
  logic [POC_BITS-1:0] poc_q;
  logic signed [6:0]   qp_q;
  logic [1:0]          idc_q;
  logic signed [3:0]   al_q;
  logic signed [3:0]   be_q;

  // Append request for this cycle
  logic                app_en;
  logic                app_ue;
  logic [16:0]         app_v;
  logic [16:0]         ue_x;
  logic [31:0]         raw_code;
  logic [5:0]          raw_len;
  logic [31:0]         app_code;
  logic [5:0]          app_len;
  logic [3:0]          trail_len;

  // Word path
  logic                out_free;
  logic                pop;
  logic                resid;
  logic                start_acc;
  logic [ACC-1:0]      acc_base;
  logic [FW-1:0]       fill_base;

  assign busy       = (state_q != S_IDLE);
  assign el_ready   = (state_q == S_DATA) && (fill_q < WIDTH_F);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_nbytes = out_nbytes_q;
  assign out_last   = out_last_q;
  assign slice_end  = slice_end_q;

  assign start_acc  = (state_q == S_IDLE) && slice_start;
  assign out_free   = !out_valid_q || out_ready;
  // A full word is popped from any active state; the residual only in FLUSH,
  // where all full words have already left (fill < WIDTH).
  assign pop        = (state_q != S_IDLE) && (fill_q >= WIDTH_F) && out_free;
  assign resid      = (state_q == S_FLUSH) && (fill_q != '0) &&
                      (fill_q < WIDTH_F) && out_free;
  // Trailing bits: a '1' then zeros up to the byte boundary. Popped words are
  // whole bytes, so fill_q[2:0] tracks the slice's bit position mod 8.
  assign trail_len  = 4'd8 - {1'b0, fill_q[2:0]};

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    slice_end_d = 1'b0;
    app_en      = 1'b0;
    app_ue      = 1'b0;
    app_v       = '0;
    raw_code    = '0;
    raw_len     = 6'd1;

    case (state_q)
      S_IDLE: begin
        if (slice_start) begin
          hdr_idx_d = F_FIRST_MB;
          state_d   = S_HDR;
        end
      end

      S_HDR: begin
        app_en = (fill_q < WIDTH_F);
        case (hdr_idx_q)
          F_FIRST_MB: begin app_ue = 1'b1; app_v = {1'b0, fm_q};          end
          F_TYPE:     begin app_ue = 1'b1; app_v = {13'd0, st_q};         end
          F_PPS:      begin app_ue = 1'b1; app_v = {9'd0, pps_q};         end
          F_FN:       begin raw_code = 32'(fn_q);  raw_len = 6'(FN_BITS);  end
          F_POC:      begin raw_code = 32'(poc_q); raw_len = 6'(POC_BITS); end
          F_FLAG0, F_FLAG1, F_FLAG2: begin raw_code = '0; raw_len = 6'd1;  end
          F_QP:       begin app_ue = 1'b1; app_v = se_map(int'(qp_q));    end
          F_IDC:      begin app_ue = 1'b1; app_v = {15'd0, idc_q};        end
          F_ALPHA:    begin app_ue = 1'b1; app_v = se_map(int'(al_q));    end
          F_BETA:     begin app_ue = 1'b1; app_v = se_map(int'(be_q));    end
          default:    app_en = 1'b0;
        endcase
        if (app_en) begin
          // Deblocking offsets exist only when the filter is not disabled.
          if (((hdr_idx_q == F_IDC) && (idc_q == 2'd1)) || (hdr_idx_q == F_BETA)) begin
            state_d = S_DATA;
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        app_en   = el_valid && el_ready;
        app_ue   = !el_kind;
        app_v    = {1'b0, el_data[15:0]};
        // Right-align the MSB-aligned chunk; dropped LSBs are don't-care.
        raw_code = el_data >> (6'd32 - el_len);
        raw_len  = el_len;
        if (app_en && el_last) state_d = S_TRAIL;
      end

      S_TRAIL: begin
        app_en   = (fill_q < WIDTH_F);
        raw_code = 32'd1 << (trail_len - 4'd1);
        raw_len  = {2'b00, trail_len};
        if (app_en) state_d = S_FLUSH;
      end

      S_FLUSH: begin
        if (out_valid_q && out_last_q && out_ready) begin
          state_d     = S_IDLE;
          slice_end_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_nbytes_d = out_nbytes_q;
    out_last_d   = out_last_q;
    acc_base     = acc_q;
    fill_base    = fill_q;

    if (pop) begin
      out_data_d   = acc_q[ACC-1 -: WIDTH];
      out_valid_d  = 1'b1;
      out_nbytes_d = NBW'(WIDTH / 8);
      // A slice ending exactly on a word boundary has no residual word, so
      // its final full word carries out_last.
      out_last_d   = (state_q == S_FLUSH) && (fill_q == WIDTH_F);
      acc_base     = acc_q << WIDTH;
      fill_base    = fill_q - WIDTH_F;
    end else if (resid) begin
      // Bits below fill_q are already zero, giving the zero-padded LSBs.
      out_data_d   = acc_q[ACC-1 -: WIDTH];
      out_valid_d  = 1'b1;
      out_nbytes_d = NBW'(fill_q >> 3);
      out_last_d   = 1'b1;
      acc_base     = '0;
      fill_base    = '0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
    end

    ue_x     = app_v + 17'd1;
    app_code = app_ue ? 32'(ue_x) : raw_code;
    app_len  = app_ue ? ue_len(ue_x) : raw_len;

    if (app_en) begin
      // fill_base < WIDTH and app_len <= 32, so the code always fits.
      acc_d  = acc_base | (ACC'(app_code) << (ACC_F - fill_base - FW'(app_len)));
      fill_d = fill_base + FW'(app_len);
    end else begin
      acc_d  = acc_base;
      fill_d = fill_base;
    end
  end

  // NOTE: reset is sampled on the clock edge, and all state updates use
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hdr_idx_q    <= '0;
      acc_q        <= '0;
      fill_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_nbytes_q <= '0;
      out_last_q   <= 1'b0;
      slice_end_q  <= 1'b0;
      fm_q         <= '0;
      st_q         <= '0;
      pps_q        <= '0;
      fn_q         <= '0;
      poc_q        <= '0;
      qp_q         <= '0;
      idc_q        <= '0;
      al_q         <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_nbytes_q <= out_nbytes_d;
      out_last_q   <= out_last_d;
      slice_end_q  <= slice_end_d;
      if (start_acc) begin
        fm_q  <= first_mb;
        st_q  <= slice_type;
        pps_q <= pps_id;
        fn_q  <= frame_num;
        poc_q <= poc_lsb;
        qp_q  <= qp_delta;
        idc_q <= dblk_idc;
        al_q  <= dblk_alpha;
        be_q  <= dblk_beta;
      end
    end
  end

endmodule

// File: tb/tb_gg_rowslice_writer.sv
// ---------------------------------------------------------------------------
// tb_gg_rowslice_writer
//
// Self-checking bench for gg_rowslice_writer. A bit-level reference model
// builds the expected slice as a queue of bits straight from the syntax rules
// (ue/se/u fields, elements, trailing bits), then cuts it into words. Inputs
// are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_gg_rowslice_writer;

  localparam int WIDTH    = 32;
  localparam int FN_BITS  = 4;
  localparam int POC_BITS = 4;
  localparam int NBW      = $clog2(WIDTH / 8) + 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                slice_start = 1'b0;
  logic [15:0]         first_mb = '0;
  logic [3:0]          slice_type = '0;
  logic [7:0]          pps_id = '0;
  logic [FN_BITS-1:0]  frame_num = '0;
  logic [POC_BITS-1:0] poc_lsb = '0;
  logic signed [6:0]   qp_delta = '0;
  logic [1:0]          dblk_idc = '0;
  logic signed [3:0]   dblk_alpha = '0;
  logic signed [3:0]   dblk_beta = '0;
  logic                busy;
  logic                el_valid = 1'b0;
  logic                el_ready;
  logic                el_kind = 1'b0;
  logic [31:0]         el_data = '0;
  logic [5:0]          el_len = '0;
  logic                el_last = 1'b0;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [NBW-1:0]      out_nbytes;
  logic                out_last;
  logic                slice_end;

  always #5 clk = ~clk;

  gg_rowslice_writer #(
    .WIDTH(WIDTH), .FN_BITS(FN_BITS), .POC_BITS(POC_BITS)
  ) dut (
    .clk(clk), .reset(reset), .slice_start(slice_start),
    .first_mb(first_mb), .slice_type(slice_type), .pps_id(pps_id),
    .frame_num(frame_num), .poc_lsb(poc_lsb), .qp_delta(qp_delta),
    .dblk_idc(dblk_idc), .dblk_alpha(dblk_alpha), .dblk_beta(dblk_beta),
    .busy(busy), .el_valid(el_valid), .el_ready(el_ready), .el_kind(el_kind),
    .el_data(el_data), .el_len(el_len), .el_last(el_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_nbytes(out_nbytes), .out_last(out_last), .slice_end(slice_end)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slice description used by both the driver and the model
  int h_fm, h_st, h_pps, h_fn, h_poc, h_qp, h_idc, h_al, h_be;
  bit          e_kind[$];
  logic [31:0] e_data[$];
  int          e_len[$];

  bit               exp_bits[$];
  logic [WIDTH-1:0] g_data[$];
  int               g_nb[$];
  bit               g_last[$];

  function automatic void put_u(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bits.push_back(bit'((v >> i) & 1));
  endfunction

  function automatic void put_ue(input int v);
    int x, n;
    x = v + 1;
    n = 0;
    while ((x >> (n + 1)) != 0) n++;
    for (int i = 0; i < n; i++) exp_bits.push_back(1'b0);
    put_u(x, n + 1);
  endfunction

  function automatic void put_se(input int k);
    if (k > 0) put_ue(2 * k - 1);
    else       put_ue(-2 * k);
  endfunction

  function automatic void build_model();
    logic [31:0] d;
    exp_bits.delete();
    put_ue(h_fm); put_ue(h_st); put_ue(h_pps);
    put_u(h_fn, FN_BITS); put_u(h_poc, POC_BITS);
    put_u(0, 3);
    put_se(h_qp); put_ue(h_idc);
    if (h_idc != 1) begin put_se(h_al); put_se(h_be); end
    for (int k = 0; k < e_kind.size(); k++) begin
      d = e_data[k];
      if (!e_kind[k]) put_ue(int'(d[15:0]));
      else for (int i = 0; i < e_len[k]; i++) exp_bits.push_back(d[31 - i]);
    end
    exp_bits.push_back(1'b1);
    while ((exp_bits.size() % 8) != 0) exp_bits.push_back(1'b0);
  endfunction

  task automatic set_hdr(input int fm, st, pps, fn, poc, qp, idc, al, be);
    h_fm = fm; h_st = st; h_pps = pps; h_fn = fn; h_poc = poc;
    h_qp = qp; h_idc = idc; h_al = al; h_be = be;
  endtask

  task automatic rand_hdr();
    set_hdr(($urandom_range(0, 7) == 0) ? 65534 : int'($urandom_range(0, 3000)),
            int'($urandom_range(0, 9)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 2)),
            int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
  endtask

  task automatic add_el(input bit kind, input logic [31:0] data, input int len);
    e_kind.push_back(kind); e_data.push_back(data); e_len.push_back(len);
  endtask

  task automatic rand_els(input int n);
    logic [31:0] d;
    e_kind.delete(); e_data.delete(); e_len.delete();
    for (int k = 0; k < n; k++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if (d[15:0] == 16'hFFFF) d[15:0] = 16'hFFFE;
        add_el(1'b0, d, 0);
      end else begin
        add_el(1'b1, d, int'($urandom_range(1, 32)));
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0; slice_start = 1'b0; el_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_el_ready"}, 64'(el_ready), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_slice_end"}, 64'(slice_end), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_nbytes"}, 64'(out_nbytes), 64'd0);
    reset = 1'b1;
  endtask

  // rmode: 0 = always ready, 1 = random ready, 2 = not ready for 'stall'
  // cycles then random. ign_at: cycle of a stray slice_start (0 = none).
  // abort_at: stop driving at this cycle without checking (0 = run to end).
  task automatic run_slice(input string tag, input int rmode, input int stall,
                           input int ign_at, input int abort_at);
    int n, idx, cyc, ends, done_cyc, nw, nb;
    bit done, hold;
    logic [WIDTH-1:0] held, ew;
    n = e_kind.size();
    build_model();
    g_data.delete(); g_nb.delete(); g_last.delete();
    idx = 0; cyc = 0; ends = 0; done = 0; done_cyc = 0; hold = 0; held = '0;

    @(negedge clk);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    first_mb = 16'(h_fm); slice_type = 4'(h_st); pps_id = 8'(h_pps);
    frame_num = FN_BITS'(h_fn); poc_lsb = POC_BITS'(h_poc); qp_delta = 7'(h_qp);
    dblk_idc = 2'(h_idc); dblk_alpha = 4'(h_al); dblk_beta = 4'(h_be);
    slice_start = 1'b1;

    while (cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (abort_at != 0 && cyc == abort_at) begin
        el_valid = 1'b0; slice_start = 1'b0;
        return;
      end
      if (cyc == 1) begin
        check({tag, "_busy_started"}, 64'(busy), 64'd1);
        check({tag, "_no_early_word"}, 64'(out_valid), 64'd0);
      end
      if (hold) check({tag, "_held"}, 64'(out_data), 64'(held));
      if (slice_end) ends++;
      if (done) begin
        if (cyc >= done_cyc + 3) break;
      end else if (slice_end) begin
        done = 1; done_cyc = cyc;
        check({tag, "_busy_at_end"}, 64'(busy), 64'd0);
      end

      if (cyc == ign_at) begin
        slice_start = 1'b1;
        first_mb = 16'h1234; slice_type = 4'd7; pps_id = 8'hA5;
        frame_num = '1; poc_lsb = '1; qp_delta = 7'sd20; dblk_idc = 2'd0;
        dblk_alpha = 4'sd5; dblk_beta = -4'sd3;
      end else begin
        slice_start = 1'b0;
      end

      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = (cyc <= stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
      endcase
      if (rmode == 2 && cyc == stall) begin
        check({tag, "_el_ready_stalled"}, 64'(el_ready), 64'd0);
        check({tag, "_word_waiting"}, 64'(out_valid), 64'd1);
      end
      hold = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        g_data.push_back(out_data); g_nb.push_back(int'(out_nbytes));
        g_last.push_back(out_last);
      end

      if (idx < n && !done) begin
        el_valid = (rmode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
        el_kind  = e_kind[idx];
        el_data  = e_data[idx];
        el_len   = 6'(e_len[idx]);
        el_last  = (idx == n - 1);
      end else begin
        el_valid = 1'b0;
      end
      if (el_valid && el_ready) idx++;
    end
    el_valid = 1'b0; slice_start = 1'b0; out_ready = 1'b0;

    check({tag, "_slice_end_seen"}, 64'(done), 64'd1);
    check({tag, "_slice_end_once"}, 64'(ends), 64'd1);
    check({tag, "_elements"}, 64'(idx), 64'(n));
    nw = (exp_bits.size() + WIDTH - 1) / WIDTH;
    check({tag, "_nwords"}, 64'(g_data.size()), 64'(nw));
    for (int w = 0; w < nw && w < g_data.size(); w++) begin
      ew = '0;
      for (int b = 0; b < WIDTH; b++)
        if (w * WIDTH + b < exp_bits.size()) ew[WIDTH-1-b] = exp_bits[w * WIDTH + b];
      nb = (w == nw - 1) ? (exp_bits.size() - w * WIDTH) / 8 : WIDTH / 8;
      check($sformatf("%s_w%0d_data", tag, w), 64'(g_data[w]), 64'(ew));
      check($sformatf("%s_w%0d_nbytes", tag, w), 64'(g_nb[w]), 64'(nb));
      check($sformatf("%s_w%0d_last", tag, w), 64'(g_last[w]), 64'(w == nw - 1));
    end
  endtask

  initial begin
    do_reset("reset");

    // Known header, idc=1, single zero skip run: 24 bits, 0xE6C0AB00
    set_hdr(0, 0, 0, 3, 6, -2, 1, 0, 0);
    e_kind.delete(); e_data.delete(); e_len.delete();
    add_el(1'b0, 32'h0, 0);
    run_slice("hdr_idc1", 0, 0, 0, 0);
    check("hdr_idc1_const", 64'((g_data.size() > 0) ? g_data[0] : '0), 64'h0000_0000_E6C0_AB00);
    check("hdr_idc1_nbytes", 64'((g_nb.size() > 0) ? g_nb[0] : 0), 64'd3);

    // Same header with deblocking offsets written: 0xE6C0BF00
    set_hdr(0, 0, 0, 3, 6, -2, 0, 0, 0);
    run_slice("hdr_idc0", 0, 0, 0, 0);
    check("hdr_idc0_const", 64'((g_data.size() > 0) ? g_data[0] : '0), 64'h0000_0000_E6C0_BF00);

    // Back-pressure: 32 all-ones chunks with the output stalled
    set_hdr(0, 0, 0, 3, 6, -2, 1, 0, 0);
    e_kind.delete(); e_data.delete(); e_len.delete();
    for (int k = 0; k < 32; k++) add_el(1'b1, 32'hFFFF_FFFF, 32);
    run_slice("stall_ones", 2, 40, 0, 0);

    // Longest skip-run code straddling a word boundary
    e_kind.delete(); e_data.delete(); e_len.delete();
    add_el(1'b1, 32'hA000_0000, 3);
    add_el(1'b0, 32'h0000_FFFE, 0);
    add_el(1'b1, 32'hC300_0000, 8);
    run_slice("skip_max", 1, 0, 0, 0);

    // Reset in the middle of DATA, then a clean slice
    rand_hdr(); rand_els(30);
    run_slice("abort", 1, 0, 0, 20);
    do_reset("mid_reset");
    rand_hdr(); rand_els(6);
    run_slice("after_reset", 1, 0, 0, 0);

    // Stray slice_start while busy must not disturb the running slice
    set_hdr(5, 0, 1, 9, 2, 3, 2, -4, 7);
    rand_els(8);
    run_slice("ignore_start", 1, 0, 3, 0);

    // Randomised slices
    for (int r = 0; r < 8; r++) begin
      rand_hdr(); rand_els(int'($urandom_range(1, 20)));
      run_slice($sformatf("rand%0d", r), 1, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
